// File: rtl/ram_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_bist_pkg
// Description : Shared types for the March C- RAM BIST: FSM state encoding,
//               per-state march operation decode, expected-word selects.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_bist_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_W0     = 4'd1,
        ST_R0W1_R = 4'd2,
        ST_R0W1_W = 4'd3,
        ST_R1W0_R = 4'd4,
        ST_R1W0_W = 4'd5,
        ST_RFIN   = 4'd6,
        ST_DRAIN  = 4'd7,
        ST_DONE   = 4'd8
    } bist_state_t;

    // Selects the background word: P itself or its complement.
    localparam logic EXP_P  = 1'b0;
    localparam logic EXP_NP = 1'b1;

    // March element encoding: what the RAM port does while in a given state.
    typedef struct packed {
        logic cs;   // a command is issued this cycle
        logic rd;   // 1 = read, 0 = write
        logic sel;  // word written, or word expected back (EXP_P / EXP_NP)
    } march_op_t;

    function automatic march_op_t march_op(input bist_state_t st);
        march_op_t op;
        op = '{cs: 1'b0, rd: 1'b1, sel: EXP_P};
        case (st)
            ST_W0:     op = '{cs: 1'b1, rd: 1'b0, sel: EXP_P};
            ST_R0W1_R: op = '{cs: 1'b1, rd: 1'b1, sel: EXP_P};
            ST_R0W1_W: op = '{cs: 1'b1, rd: 1'b0, sel: EXP_NP};
            ST_R1W0_R: op = '{cs: 1'b1, rd: 1'b1, sel: EXP_NP};
            ST_R1W0_W: op = '{cs: 1'b1, rd: 1'b0, sel: EXP_P};
            ST_RFIN:   op = '{cs: 1'b1, rd: 1'b1, sel: EXP_P};
            default:   ;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_march_bist_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_march_bist_if
// Description : Control/status and RAM command port of the March BIST.
//               slave  = the BIST engine, master = the surrounding system
//               (test controller drives start, RAM returns Datain).
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_march_bist_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [ADDR_WIDTH-1:0] fail_addr;
    logic [DATA_WIDTH-1:0] fail_data;
    logic                  CS;
    logic                  R_W;
    logic [ADDR_WIDTH-1:0] Addr;
    logic [DATA_WIDTH-1:0] Dataout;
    logic [DATA_WIDTH-1:0] Datain;

    modport slave (
        input  start, Datain,
        output busy, done, pass, fail_addr, fail_data, CS, R_W, Addr, Dataout
    );

    modport master (
        output start, Datain,
        input  busy, done, pass, fail_addr, fail_data, CS, R_W, Addr, Dataout
    );
endinterface
`default_nettype wire

// File: rtl/ram_bist_cmp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ram_bist_cmp_pipe
// Description : READ_LATENCY-deep delay line of {valid, addr, expected-select}
//               aligned with RAM read data, plus the word comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_bist_cmp_pipe #(
    parameter int                    ADDR_WIDTH   = 12,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] PATTERN      = 'h5555_5555
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_push,
    input  wire logic [ADDR_WIDTH-1:0] i_push_addr,
    input  wire logic                  i_push_exp,
    input  wire logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                       mismatch,
    output logic [ADDR_WIDTH-1:0]      mm_addr,
    output logic [DATA_WIDTH-1:0]      mm_data
);
    import ram_bist_pkg::*;

    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY-1:0] exp_q, exp_d;
    logic [ADDR_WIDTH-1:0]   adr_q [READ_LATENCY];
    logic [ADDR_WIDTH-1:0]   adr_d [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   w_exp_word;

    // Shift: stage 0 takes the command presented this cycle.
    always_comb begin
        vld_d[0] = i_push;
        exp_d[0] = i_push_exp;
        adr_d[0] = i_push_addr;
        for (int k = 1; k < READ_LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            exp_d[k] = exp_q[k-1];
            adr_d[k] = adr_q[k-1];
        end
    end

    // Delay line registers; reset flushes every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            exp_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                adr_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            exp_q <= exp_d;
            adr_q <= adr_d;
        end
    end

    // The last stage lines up with the cycle its read data is on i_rd_data.
    assign w_exp_word = (exp_q[READ_LATENCY-1] == EXP_NP) ? ~PATTERN : PATTERN;
    assign mismatch   = vld_q[READ_LATENCY-1] && (i_rd_data != w_exp_word);
    assign mm_addr    = adr_q[READ_LATENCY-1];
    assign mm_data    = i_rd_data;

endmodule
`default_nettype wire

// File: rtl/ram_march_bist.sv
`default_nettype none
// ============================================================================
// Module      : ram_march_bist
// Description : March C- BIST initiator for a single-port RAM: W0 up,
//               R0W1 up, R1W0 down, final read up, then drain and report.
//               WORDS must be >= 2; READ_LATENCY must be 1..4.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_march_bist #(
    parameter int                    ADDR_WIDTH   = 12,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    WORDS        = 2**ADDR_WIDTH,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] PATTERN      = 'h5555_5555
) (
    input  wire logic            CLK,
    input  wire logic            RST,
    ram_march_bist_if.slave      bus
);
    import ram_bist_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(WORDS - 1);
    localparam logic [2:0]            LAST_DRAIN = 3'(READ_LATENCY - 1);

    bist_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            drain_q, drain_d;
    logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic                  fail_seen_q, fail_seen_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
    logic                  cs_q, cs_d, rw_q, rw_d, exp_sel_q, exp_sel_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    march_op_t             op_next;
    logic                  mismatch;
    logic [ADDR_WIDTH-1:0] mm_addr;
    logic [DATA_WIDTH-1:0] mm_data;

    ram_bist_cmp_pipe #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY),
        .PATTERN      (PATTERN)
    ) u_cmp_pipe (
        .clk         (CLK),
        .rst         (RST),
        .i_push      (cs_q & rw_q),
        .i_push_addr (addr_q),
        .i_push_exp  (exp_sel_q),
        .i_rd_data   (bus.Datain),
        .mismatch    (mismatch),
        .mm_addr     (mm_addr),
        .mm_data     (mm_data)
    );

    // Next state: march sequencing, address counter, drain timer, status.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        drain_d     = drain_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_seen_d = fail_seen_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d     = ST_W0;
                    addr_d      = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_seen_d = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                end
            end
            ST_W0: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_R0W1_R;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_R0W1_R: state_d = ST_R0W1_W;
            ST_R0W1_W: begin
                // At the top the address is already WORDS-1, where R1W0 starts.
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_R1W0_R;
                end else begin
                    state_d = ST_R0W1_R;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_R1W0_R: state_d = ST_R1W0_W;
            ST_R1W0_W: begin
                if (addr_q == '0) begin
                    state_d = ST_RFIN;
                end else begin
                    state_d = ST_R1W0_R;
                    addr_d  = addr_q - ADDR_WIDTH'(1);
                end
            end
            ST_RFIN: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = ~fail_seen_q;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // First mismatch wins: record it and abort into a fresh drain period.
        if (busy_q && mismatch && !fail_seen_q) begin
            fail_seen_d = 1'b1;
            fail_addr_d = mm_addr;
            fail_data_d = mm_data;
            state_d     = ST_DRAIN;
            drain_d     = '0;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            pass_d      = 1'b0;
        end
    end

    // Command decode from the next state so the RAM port is fully registered.
    assign op_next = march_op(state_d);
    always_comb begin
        cs_d      = op_next.cs;
        rw_d      = op_next.rd;
        exp_sel_d = op_next.sel;
        dout_d    = '0;
        if (op_next.cs && !op_next.rd) begin
            dout_d = (op_next.sel == EXP_NP) ? ~PATTERN : PATTERN;
        end
    end

    // State, counters, status and command registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_seen_q <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            cs_q        <= 1'b0;
            rw_q        <= 1'b1;
            exp_sel_q   <= EXP_P;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_seen_q <= fail_seen_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            cs_q        <= cs_d;
            rw_q        <= rw_d;
            exp_sel_q   <= exp_sel_d;
            dout_q      <= dout_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_addr = fail_addr_q;
    assign bus.fail_data = fail_data_q;
    assign bus.CS        = cs_q;
    assign bus.R_W       = rw_q;
    assign bus.Addr      = addr_q;
    assign bus.Dataout   = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_march_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_march_bist
// Description : Bench for ram_march_bist, WORDS=8, with READ_LATENCY 1 and 3
//               instances, a behavioural RAM each, and injectable faults.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_march_bist;

    localparam logic [31:0] P  = 32'h5555_5555;
    localparam logic [31:0] NP = 32'hAAAA_AAAA;

    typedef struct {
        int          sel;        // 0: latency-1 DUT, 1: latency-3 DUT
        int          fmode;      // 0 none, 1 stuck-at-0 cell bit, 2 write 5 also hits 6
        int          faddr;
        int          fbit;
        int          restart_at; // cycle to pulse start while busy, -1 for none
        int          cycles;     // edges from E0 to done
        logic        pass;
        logic [2:0]  fa;
        logic [31:0] fd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_r = 1'b0;
    int   sel = 0;
    int   fmode = 0;
    int   faddr = 0;
    int   fbit = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ram_march_bist_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) b1 ();
    ram_march_bist_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) b3 ();

    ram_march_bist #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .WORDS(8),
                     .READ_LATENCY(1), .PATTERN(P)) dut1 (
        .CLK (clk), .RST (rst), .bus (b1.slave));

    ram_march_bist #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .WORDS(8),
                     .READ_LATENCY(3), .PATTERN(P)) dut3 (
        .CLK (clk), .RST (rst), .bus (b3.slave));

    logic [31:0] mem1 [8];
    logic [31:0] mem3 [8];
    logic [31:0] rd1, rd3a, rd3b, rd3c;

    assign b1.start  = start_r && (sel == 0);
    assign b3.start  = start_r && (sel == 1);
    assign b1.Datain = rd1;
    assign b3.Datain = rd3c;

    function automatic logic [31:0] stored(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        if (fmode == 1 && int'(a) == faddr) r[fbit] = 1'b0;
        return r;
    endfunction

    always @(posedge clk) begin
        if (b1.CS && !b1.R_W) begin
            mem1[b1.Addr] <= stored(b1.Addr, b1.Dataout);
            if (fmode == 2 && b1.Addr == 3'd5) mem1[6] <= stored(3'd6, b1.Dataout);
        end
        if (b1.CS && b1.R_W) rd1 <= mem1[b1.Addr];
    end

    always @(posedge clk) begin
        if (b3.CS && !b3.R_W) begin
            mem3[b3.Addr] <= stored(b3.Addr, b3.Dataout);
            if (fmode == 2 && b3.Addr == 3'd5) mem3[6] <= stored(3'd6, b3.Dataout);
        end
        if (b3.CS && b3.R_W) rd3a <= mem3[b3.Addr];
        rd3b <= rd3a;
        rd3c <= rd3b;
    end

    logic        cur_cs, cur_rw, cur_busy, cur_done, cur_pass;
    logic [2:0]  cur_addr, cur_fa;
    logic [31:0] cur_dout, cur_fd;

    always_comb begin
        cur_cs = b1.CS; cur_rw = b1.R_W; cur_busy = b1.busy; cur_done = b1.done;
        cur_pass = b1.pass; cur_addr = b1.Addr; cur_fa = b1.fail_addr;
        cur_dout = b1.Dataout; cur_fd = b1.fail_data;
        if (sel == 1) begin
            cur_cs = b3.CS; cur_rw = b3.R_W; cur_busy = b3.busy; cur_done = b3.done;
            cur_pass = b3.pass; cur_addr = b3.Addr; cur_fa = b3.fail_addr;
            cur_dout = b3.Dataout; cur_fd = b3.fail_data;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Command k of a WORDS=8 March C- run, derived by index arithmetic.
    function automatic void exp_cmd(input int k, output logic rw, output logic [2:0] a,
                                    output logic [31:0] d);
        int j;
        if (k < 8) begin
            rw = 1'b0; a = 3'(k); d = P;
        end else if (k < 24) begin
            j = k - 8; a = 3'(j / 2); rw = (j % 2 == 0); d = rw ? P : NP;
        end else if (k < 40) begin
            j = k - 24; a = 3'(7 - j / 2); rw = (j % 2 == 0); d = rw ? NP : P;
        end else begin
            rw = 1'b1; a = 3'(k - 40); d = P;
        end
    endfunction

    function automatic logic [127:0] snapshot();
        return 128'({cur_busy, cur_done, cur_pass, cur_fa, cur_fd,
                     cur_cs, cur_rw, cur_addr, cur_dout});
    endfunction

    // Only R_W is 1 at reset; it sits above Addr (3) and Dataout (32).
    localparam logic [127:0] RST_SNAP = 128'h1 << 35;

    task automatic run_vec(input vec_t v, input int idx);
        int          k, last_cs, cmd_bad, first_bad, rl;
        logic        rw;
        logic [2:0]  a;
        logic [31:0] d;
        sel = v.sel; fmode = v.fmode; faddr = v.faddr; fbit = v.fbit;
        rl = (v.sel == 1) ? 3 : 1;
        @(negedge clk); start_r = 1'b1;
        @(posedge clk); #1; start_r = 1'b0;
        chk($sformatf("v%0d_busy_after_start", idx), 128'(cur_busy), 128'(1));
        chk($sformatf("v%0d_done_cleared", idx), 128'(cur_done), 128'(0));
        k = 0; last_cs = -1; cmd_bad = 0; first_bad = -1;
        while (!cur_done && k < 200) begin
            if (cur_cs) begin
                last_cs = k;
                exp_cmd(k, rw, a, d);
                if (k > 47 || cur_rw !== rw || cur_addr !== a || (!rw && cur_dout !== d)) begin
                    if (cmd_bad == 0) first_bad = k;
                    cmd_bad++;
                end
            end
            start_r = (k == v.restart_at);
            @(posedge clk); #1;
            k++;
        end
        start_r = 1'b0;
        chk($sformatf("v%0d_done_within_bound", idx), 128'(cur_done), 128'(1));
        chk($sformatf("v%0d_cycles_to_done", idx), 128'(k), 128'(v.cycles));
        chk($sformatf("v%0d_busy_low_at_done", idx), 128'(cur_busy), 128'(0));
        chk($sformatf("v%0d_pass", idx), 128'(cur_pass), 128'(v.pass));
        chk($sformatf("v%0d_fail_addr", idx), 128'(cur_fa), 128'(v.fa));
        chk($sformatf("v%0d_fail_data", idx), 128'(cur_fd), 128'(v.fd));
        chk($sformatf("v%0d_last_cs_cycle", idx), 128'(last_cs), 128'(v.cycles - rl - 1));
        chk($sformatf("v%0d_cmd_stream_first_bad_%0d", idx, first_bad), 128'(cmd_bad), 128'(0));
    endtask

    initial begin
        vec_t vecs [9];
        // Fault-free latency 1: 48 commands, done at E0+49.
        vecs[0] = '{0, 0, 0, 0, -1, 49, 1'b1, 3'd0, 32'h0};
        // Bit 0 of addr 3 stuck at 0: the R0W1 read of 3 (cmd 14) sees P with bit 0 clear.
        vecs[1] = '{0, 1, 3, 0, -1, 17, 1'b0, 3'd3, 32'h5555_5554};
        // Bit 1 of addr 3 stuck at 0: ~P stored wrong, caught by R1W0 read (cmd 32).
        vecs[2] = '{0, 1, 3, 1, -1, 35, 1'b0, 3'd3, 32'hAAAA_AAA8};
        // Top address fault: R0W1 read of 7 is cmd 22.
        vecs[3] = '{0, 1, 7, 0, -1, 25, 1'b0, 3'd7, 32'h5555_5554};
        // Write to 5 also writes 6: R0W1 read of 6 (cmd 20) returns ~P.
        vecs[4] = '{0, 2, 0, 0, -1, 23, 1'b0, 3'd6, NP};
        // start pulsed while busy is ignored.
        vecs[5] = '{0, 0, 0, 0, 10, 49, 1'b1, 3'd0, 32'h0};
        // Latency 3 fault-free: done at E0+51.
        vecs[6] = '{1, 0, 0, 0, -1, 51, 1'b1, 3'd0, 32'h0};
        // Latency 3, addr 0 bit 0: cmd 8 compared at E0+12, done E0+15.
        vecs[7] = '{1, 1, 0, 0, -1, 15, 1'b0, 3'd0, 32'h5555_5554};
        // Latency 3, addr 0 bit 1: last R1W0 read (cmd 38) compared at E0+42.
        vecs[8] = '{1, 1, 0, 1, -1, 45, 1'b0, 3'd0, 32'hAAAA_AAA8};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sel = 0; #1;
        chk("reset_state_lat1", snapshot(), RST_SNAP);
        sel = 1; #1;
        chk("reset_state_lat3", snapshot(), RST_SNAP);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // start while done: done is held, then cleared by the accepted start.
        sel = 0; #1;
        chk("done_held_before_restart", 128'(cur_done), 128'(1));
        run_vec(vecs[0], 9);

        // Reset in the middle of a run.
        sel = 0; fmode = 0;
        @(negedge clk); start_r = 1'b1;
        @(posedge clk); #1; start_r = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("busy_before_mid_reset", 128'(cur_busy), 128'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_run_reset_state", snapshot(), RST_SNAP);
        chk("mid_run_reset_cs", 128'(cur_cs), 128'(0));
        @(negedge clk); rst = 1'b0;
        run_vec(vecs[0], 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
